// File: rtl/stmtlocals_lane_sum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stmtlocals_lane_sum: folds a LANES*LANE_W word into a LANE_W sum, one      |
// | lane per cycle. Optional macro: STMTLOCALS_SAT_EN (saturating add). Rev 1.0|
// +--------------------------------------------------------------------------+
module stmtlocals_lane_sum #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANE_W-1:0]       out_sum,
  output logic                    out_ovf
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [LANES*LANE_W-1:0] word;
  logic [LANE_W-1:0]       acc;
  logic [LANE_W-1:0]       acc_nxt;
  logic [IDX_W-1:0]        idx;
  logic                    ovf;
  logic                    ovf_nxt;
  logic                    last_lane;

  assign last_lane = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = SUM;
      SUM:     if (last_lane) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane increment widened by one bit so a lane of all-ones still carries out.
  always_comb begin : lane_add
    logic [LANE_W:0] tmp;
    logic [LANE_W:0] s;
    logic            carry;
    tmp   = {1'b0, word[idx*LANE_W +: LANE_W]} + (LANE_W+1)'(1);
    s     = {1'b0, acc} + tmp;
    carry = s[LANE_W];
`ifdef STMTLOCALS_SAT_EN
    acc_nxt = carry ? {LANE_W{1'b1}} : s[LANE_W-1:0];
`else
    acc_nxt = s[LANE_W-1:0];
`endif
    ovf_nxt = ovf | carry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word <= '0;
      acc  <= '0;
      idx  <= '0;
      ovf  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            word <= in_data;
            acc  <= '0;
            idx  <= '0;
            ovf  <= 1'b0;
          end
        end
        SUM: begin
          acc <= acc_nxt;
          ovf <= ovf_nxt;
          idx <= last_lane ? '0 : idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = acc;
  assign out_ovf   = ovf;

endmodule
`default_nettype wire

// File: tb/tb_stmtlocals_lane_sum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stmtlocals_lane_sum: directed bench for stmtlocals_lane_sum. Rev 1.0   |
// +--------------------------------------------------------------------------+
module tb_stmtlocals_lane_sum;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_sum;
  logic         out_ovf;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t1, t2;

  stmtlocals_lane_sum #(.LANES(4), .LANE_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // Accept one word with out_ready high and check latency and result.
  task automatic run_word(input string tag, input logic [127:0] w,
                          input logic [31:0] exp_sum, input logic exp_ovf);
    in_data = w; in_valid = 1'b1; out_ready = 1'b1;
    wait_ready();
    step();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    repeat (3) step();
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, out_sum, exp_sum);
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    step();
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
    chk({tag, "_vdrop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", out_sum, 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    run_word("basic", {32'd4, 32'd3, 32'd2, 32'd1}, 32'd14, 1'b0);
`ifdef STMTLOCALS_SAT_EN
    run_word("allones", {4{32'hFFFF_FFFF}}, 32'hFFFF_FFFF, 1'b1);
    run_word("fe", {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE}, 32'hFFFF_FFFF, 1'b1);
`else
    run_word("allones", {4{32'hFFFF_FFFF}}, 32'd0, 1'b1);
    run_word("fe", {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE}, 32'd2, 1'b1);
`endif

    // Backpressure: hold DONE for 5 cycles while new data is offered.
    in_data = {32'd40, 32'd30, 32'd20, 32'd10}; in_valid = 1'b1; out_ready = 1'b0;
    wait_ready();
    step();
    in_data = {4{32'd9}};
    repeat (4) step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", out_sum, 32'd104);
      chk("bp_ovf", 32'(out_ovf), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_release", 32'(in_ready), 32'd1);
    in_data = {32'd4, 32'd3, 32'd2, 32'd1};
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_sum", out_sum, 32'd14);
    step();

    // Reset during the second SUM cycle.
    in_data = {4{32'd5}}; in_valid = 1'b1;
    wait_ready();
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_acc", out_sum, 32'd0);
    step();
    chk("midrst_novalid", 32'(out_valid), 32'd0);
    run_word("zeros", 128'd0, 32'd4, 1'b0);

    // Back-to-back with in_valid held high.
    in_data = {4{32'd1}}; in_valid = 1'b1; out_ready = 1'b1;
    wait_ready();
    step();
    t1 = cyc;
    in_data = 128'd0;
    wait_valid();
    chk("b2b_sum0", out_sum, 32'd8);
    wait_ready();
    step();
    t2 = cyc;
    in_valid = 1'b0;
    wait_valid();
    chk("b2b_sum1", out_sum, 32'd4);
    chk("b2b_spacing", 32'(t2 - t1), 32'd6);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stmtlocals_lane_sum.md
# stmtlocals_lane_sum

Sequential reduction stage that consumes the 128-bit result word of the statement-locals combinational stage and folds it into a single 32-bit sum. Each lane is incremented through a block-local temporary, then accumulated, one lane per cycle. Input and output use valid/ready handshakes. The block also serves as a cosim target for procedural locals inside clocked `always_ff` blocks.

## Interface
- `LANES`, default 4: number of lanes per input word.
- `LANE_W`, default 32: lane width; input width is `LANES*LANE_W`, which is 128 by default.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the block accepts a word.
- `in_data` input `LANES*LANE_W`: word to reduce; lane k is `in_data[k*LANE_W +: LANE_W]`.
- `out_valid` output 1: `out_sum` and `out_ovf` are valid.
- `out_ready` input 1: downstream accepts the result.
- `out_sum` output `LANE_W`: reduced sum.
- `out_ovf` output 1: sticky overflow flag for the current word.

## Operation
- The FSM has three states: IDLE, SUM and DONE.
- **IDLE**
  - `in_ready`=1 (forced 0 while `rst_n`=0).
  - On `in_valid && in_ready`: capture `in_data`, set `acc`=0, `idx`=0, `ovf`=0, and go to SUM.
- **SUM**, one lane per cycle:
  - Block-local temporaries: `tmp` = {1'b0, lane[idx]} + 1, `LANE_W+1` bits, so the lane increment never loses its carry.
  - `s` = `acc` + `tmp`, `LANE_W+1` bits; `carry` = `s[LANE_W]`.
  - `acc` <= `s[LANE_W-1:0]`; `ovf` <= `ovf | carry`.
  - `idx` increments. After lane `LANES-1` the FSM goes to DONE.
  - `in_ready`=0 throughout.
- **DONE**
  - `out_valid`=1, `out_sum`=`acc`, `out_ovf`=`ovf`, all held stable until `out_ready`.
  - On `out_ready` the FSM returns to IDLE. `in_ready` stays 0 in DONE, so input and output never overlap.
- `in_data` is ignored outside IDLE. `in_valid` may drop without consequence when it is not accepted.
- `out_ready` is ignored outside DONE.
- Reset values: state=IDLE, `acc`=0, `idx`=0, `ovf`=0, captured word=0, `out_valid`=0, `out_sum`=0, `out_ovf`=0.
- Reset mid-operation, in SUM or DONE: at the next edge the FSM is in IDLE. The partial result is discarded and no `out_valid` pulse is produced.

## Timing
- The accept edge is E.
- SUM occupies edges E+1 through E+`LANES`.
- `out_valid` rises in the cycle following edge E+`LANES`. This is 4 cycles after acceptance by default.
- With `out_ready` held high, the next accept happens no earlier than edge E+`LANES`+2.
  - Peak throughput is one word per `LANES`+2 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.

## Configuration
- `STMTLOCALS_SAT_EN`
  - **Defined:** saturating accumulation. When `carry`=1, `acc` <= all-ones and `ovf` is set. Once saturated, `acc` stays all-ones for the rest of the word, because every further add carries.
  - **Undefined:** wrap-around modulo 2^`LANE_W`, with `ovf` reporting that a wrap occurred.
  - The timing and handshake are identical in both builds.

## Test plan
- Lanes {1,2,3,4} (lane0=1), `out_ready`=1 → `out_valid` 4 cycles after accept, `out_sum`=14, `out_ovf`=0, back in IDLE one cycle later.
- All lanes 0xFFFFFFFF:
  - Without the macro → `out_sum`=0, `out_ovf`=1.
  - With `STMTLOCALS_SAT_EN` → `out_sum`=0xFFFFFFFF, `out_ovf`=1.
- lane0=0xFFFFFFFE, other lanes 0:
  - Without the macro → `out_sum`=2, `out_ovf`=1.
  - With the macro → `out_sum`=0xFFFFFFFF, `out_ovf`=1.
- Backpressure: `out_ready`=0 for 5 cycles in DONE while `in_valid`=1 with new data.
  - `out_valid`, `out_sum` and `out_ovf` are held.
  - `in_ready`=0 and the new data is not captured.
  - Data is captured only after `out_ready` completes the handshake and the FSM returns to IDLE.
- Reset: `rst_n`=0 for one edge during the second SUM cycle → next cycle in IDLE, `in_ready`=1, `out_valid`=0, `acc`=0. A following word {0,0,0,0} yields `out_sum`=4, `out_ovf`=0.
- Back-to-back: two words {1,1,1,1} then {0,0,0,0} with `in_valid` held high and `out_ready`=1 → results 8 then 4, accepts exactly 6 cycles apart.
